// File: rtl/array_stats_pkg.sv
// Shared types and width helpers for the array statistics engine.
package array_stats_pkg;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  function automatic int sum_w(input int data_w, input int addr_w);
    return data_w + addr_w;
  endfunction

  function automatic int cnt_w(input int addr_w);
    return addr_w + 1;
  endfunction

endpackage

// File: rtl/array_stats_acc.sv
// Running sum / odd-count / min / max accumulators. The *_nxt outputs already
// include the current data word so the final element can be captured on the same edge.
module array_stats_acc
  import array_stats_pkg::*;
#(
  parameter int  DATA_W = 8,
  parameter int  ADDR_W = 3,
  localparam int SUM_W  = sum_w(DATA_W, ADDR_W),
  localparam int CNT_W  = cnt_w(ADDR_W)
) (
  input  logic              Clk,
  input  logic              Rst,
  input  logic              clr,
  input  logic              en,
  input  logic [DATA_W-1:0] data,
  output logic [SUM_W-1:0]  sum_nxt,
  output logic [CNT_W-1:0]  odd_nxt,
  output logic [DATA_W-1:0] min_nxt,
  output logic [DATA_W-1:0] max_nxt
);

  logic [SUM_W-1:0]  sum_q;
  logic [CNT_W-1:0]  odd_q;
  logic [DATA_W-1:0] min_q;
  logic [DATA_W-1:0] max_q;

  assign sum_nxt = sum_q + SUM_W'(data);
  assign odd_nxt = odd_q + CNT_W'(data[0]);
  assign min_nxt = (data < min_q) ? data : min_q;
  assign max_nxt = (data > max_q) ? data : max_q;

  always_ff @(posedge Clk) begin
    if (Rst || clr) begin
      sum_q <= '0;
      odd_q <= '0;
      min_q <= '1;
      max_q <= '0;
    end else if (en) begin
      sum_q <= sum_nxt;
      odd_q <= odd_nxt;
      min_q <= min_nxt;
      max_q <= max_nxt;
    end
  end

endmodule

// File: rtl/array_stats.sv
// Walks a DEPTH-entry synchronous-read memory and reports sum, average,
// odd count, min and max; results hold until the next run completes.
module array_stats
  import array_stats_pkg::*;
#(
  parameter int  DATA_W = 8,
  parameter int  DEPTH  = 8,
  localparam int ADDR_W = $clog2(DEPTH),
  localparam int SUM_W  = sum_w(DATA_W, ADDR_W),
  localparam int CNT_W  = cnt_w(ADDR_W)
) (
  input  logic              Clk,
  input  logic              Rst,
  input  logic              go,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [DATA_W-1:0] mem_data,
  output logic              busy,
  output logic              done,
  output logic [SUM_W-1:0]  sum,
  output logic [DATA_W-1:0] average,
  output logic [CNT_W-1:0]  countodd,
  output logic [DATA_W-1:0] min,
  output logic [DATA_W-1:0] max
);

  localparam logic [ADDR_W-1:0] LAST = ADDR_W'(DEPTH - 1);

  state_t            state;
  logic [1:0]        vld_pipe;  // [0] address issued this cycle, [1] mem_data valid this cycle
  logic [ADDR_W-1:0] addr;
  logic              clr, en, fin;
  logic [SUM_W-1:0]  sum_nxt;
  logic [CNT_W-1:0]  odd_nxt;
  logic [DATA_W-1:0] min_nxt, max_nxt;

  assign clr      = go && (state != RUN);
  assign en       = (state == RUN) && vld_pipe[1];
  assign fin      = en && !vld_pipe[0];
  assign mem_addr = addr;

  array_stats_acc #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) u_acc (
    .Clk     (Clk),
    .Rst     (Rst),
    .clr     (clr),
    .en      (en),
    .data    (mem_data),
    .sum_nxt (sum_nxt),
    .odd_nxt (odd_nxt),
    .min_nxt (min_nxt),
    .max_nxt (max_nxt)
  );

  always_ff @(posedge Clk) begin
    if (Rst) begin
      state    <= IDLE;
      vld_pipe <= '0;
      addr     <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
      sum      <= '0;
      average  <= '0;
      countodd <= '0;
      min      <= '0;
      max      <= '0;
    end else begin
      case (state)
        IDLE, DONE: begin
          if (go) begin
            state    <= RUN;
            addr     <= '0;
            vld_pipe <= 2'b01;
            busy     <= 1'b1;
            done     <= 1'b0;
          end
        end
        RUN: begin
          vld_pipe[1] <= vld_pipe[0];
          if (vld_pipe[0]) begin
            if (addr == LAST) vld_pipe[0] <= 1'b0;
            else              addr        <= addr + 1'b1;
          end
          // last element drains one cycle after the final address stops issuing
          if (fin) begin
            state    <= DONE;
            busy     <= 1'b0;
            done     <= 1'b1;
            sum      <= sum_nxt;
            average  <= sum_nxt[SUM_W-1:ADDR_W];
            countodd <= odd_nxt;
            min      <= min_nxt;
            max      <= max_nxt;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_array_stats.sv
// Directed bench: 8x8 instance for most scenarios, 16x4 instance for depth/width scaling.
module tb_array_stats;

  logic Clk = 1'b0;
  logic Rst;
  always #5 Clk = ~Clk;

  int checks = 0;
  int errors = 0;

  // DUT a: DEPTH=8, DATA_W=8
  logic       go_a;
  logic [2:0] addr_a;
  logic [7:0] data_a;
  logic       busy_a, done_a;
  logic [10:0] sum_a;
  logic [7:0] avg_a;
  logic [3:0] odd_a;
  logic [7:0] min_a, max_a;
  logic [7:0] mem_a [8];
  always @(posedge Clk) data_a <= mem_a[addr_a];

  array_stats #(.DATA_W(8), .DEPTH(8)) dut_a (
    .Clk(Clk), .Rst(Rst), .go(go_a), .mem_addr(addr_a), .mem_data(data_a),
    .busy(busy_a), .done(done_a), .sum(sum_a), .average(avg_a),
    .countodd(odd_a), .min(min_a), .max(max_a)
  );

  // DUT b: DEPTH=16, DATA_W=4
  logic       go_b;
  logic [3:0] addr_b;
  logic [3:0] data_b;
  logic       busy_b, done_b;
  logic [7:0] sum_b;
  logic [3:0] avg_b;
  logic [4:0] odd_b;
  logic [3:0] min_b, max_b;
  logic [3:0] mem_b [16];
  always @(posedge Clk) data_b <= mem_b[addr_b];

  array_stats #(.DATA_W(4), .DEPTH(16)) dut_b (
    .Clk(Clk), .Rst(Rst), .go(go_b), .mem_addr(addr_b), .mem_data(data_b),
    .busy(busy_b), .done(done_b), .sum(sum_b), .average(avg_b),
    .countodd(odd_b), .min(min_b), .max(max_b)
  );

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  // Pulse go on DUT a and return cycles from the go edge to done (-1 on timeout).
  task automatic run_a(output int lat);
    go_a = 1'b1;
    tick();
    go_a = 1'b0;
    lat = 0;
    while (!done_a && lat < 60) begin
      tick();
      lat++;
    end
    if (!done_a) lat = -1;
  endtask

  task automatic test_reset();
    Rst = 1'b1; go_a = 1'b0; go_b = 1'b0;
    repeat (3) tick();
    checks++; if ({busy_a, done_a} !== 2'b00) begin errors++; $display("FAIL reset_a_flags: busy/done=%b expected 00", {busy_a, done_a}); end
    checks++; if (addr_a !== 3'd0) begin errors++; $display("FAIL reset_a_addr: got %0d expected 0", addr_a); end
    checks++; if ({sum_a, avg_a, odd_a, min_a, max_a} !== 39'd0) begin errors++; $display("FAIL reset_a_results: sum=%0d avg=%0d odd=%0d min=%0d max=%0d expected all 0", sum_a, avg_a, odd_a, min_a, max_a); end
    checks++; if ({busy_b, done_b, addr_b, sum_b, avg_b, odd_b, min_b, max_b} !== 35'd0) begin errors++; $display("FAIL reset_b: outputs=%h expected 0", {busy_b, done_b, addr_b, sum_b, avg_b, odd_b, min_b, max_b}); end
    Rst = 1'b0;
    repeat (2) tick();
    checks++; if ({busy_a, done_a, addr_a} !== 5'd0) begin errors++; $display("FAIL idle_hold: busy/done/addr=%b expected 0", {busy_a, done_a, addr_a}); end
  endtask

  task automatic test_basic();
    int lat;
    for (int i = 0; i < 8; i++) mem_a[i] = 8'(i + 1);
    run_a(lat);
    checks++; if (lat !== 9) begin errors++; $display("FAIL basic_latency: got %0d expected 9", lat); end
    checks++; if (busy_a !== 1'b0) begin errors++; $display("FAIL basic_busy: got %b expected 0", busy_a); end
    checks++; if (sum_a !== 11'd36) begin errors++; $display("FAIL basic_sum: got %0d expected 36", sum_a); end
    checks++; if (avg_a !== 8'd4) begin errors++; $display("FAIL basic_avg: got %0d expected 4", avg_a); end
    checks++; if (odd_a !== 4'd4) begin errors++; $display("FAIL basic_odd: got %0d expected 4", odd_a); end
    checks++; if (min_a !== 8'd1) begin errors++; $display("FAIL basic_min: got %0d expected 1", min_a); end
    checks++; if (max_a !== 8'd8) begin errors++; $display("FAIL basic_max: got %0d expected 8", max_a); end
  endtask

  task automatic test_extremes();
    int lat;
    for (int i = 0; i < 8; i++) mem_a[i] = 8'hFF;
    run_a(lat);
    checks++; if (lat !== 9) begin errors++; $display("FAIL ones_latency: got %0d expected 9", lat); end
    checks++; if (sum_a !== 11'd2040) begin errors++; $display("FAIL ones_sum: got %0d expected 2040", sum_a); end
    checks++; if (avg_a !== 8'd255) begin errors++; $display("FAIL ones_avg: got %0d expected 255", avg_a); end
    checks++; if (odd_a !== 4'd8) begin errors++; $display("FAIL ones_odd: got %0d expected 8", odd_a); end
    checks++; if ({min_a, max_a} !== 16'hFFFF) begin errors++; $display("FAIL ones_minmax: min=%0d max=%0d expected 255/255", min_a, max_a); end
    for (int i = 0; i < 8; i++) mem_a[i] = 8'h00;
    run_a(lat);
    checks++; if (lat !== 9) begin errors++; $display("FAIL zeros_latency: got %0d expected 9", lat); end
    checks++; if ({sum_a, avg_a, odd_a} !== 23'd0) begin errors++; $display("FAIL zeros_sum_avg_odd: sum=%0d avg=%0d odd=%0d expected 0", sum_a, avg_a, odd_a); end
    checks++; if ({min_a, max_a} !== 16'h0000) begin errors++; $display("FAIL zeros_minmax: min=%0d max=%0d expected 0/0", min_a, max_a); end
  endtask

  // Cycle-accurate walk: mem_addr=k after go-edge+k, done at go-edge+9.
  task automatic test_minmax();
    logic [7:0] v [8] = '{8'd9, 8'd3, 8'd200, 8'd3, 8'd50, 8'd201, 8'd7, 8'd100};
    for (int i = 0; i < 8; i++) mem_a[i] = v[i];
    go_a = 1'b1;
    tick();
    go_a = 1'b0;
    checks++; if ({busy_a, done_a, addr_a} !== 5'b10_000) begin errors++; $display("FAIL mm_start: busy=%b done=%b addr=%0d expected 1/0/0", busy_a, done_a, addr_a); end
    for (int k = 1; k < 8; k++) begin
      tick();
      checks++; if ({busy_a, done_a, addr_a} !== {2'b10, 3'(k)}) begin errors++; $display("FAIL mm_addr_%0d: busy=%b done=%b addr=%0d expected 1/0/%0d", k, busy_a, done_a, addr_a, k); end
    end
    tick();
    checks++; if ({busy_a, done_a, addr_a} !== 5'b10_111) begin errors++; $display("FAIL mm_edge8: busy=%b done=%b addr=%0d expected 1/0/7", busy_a, done_a, addr_a); end
    tick();
    checks++; if ({busy_a, done_a, addr_a} !== 5'b01_111) begin errors++; $display("FAIL mm_edge9: busy=%b done=%b addr=%0d expected 0/1/7", busy_a, done_a, addr_a); end
    checks++; if (sum_a !== 11'd573) begin errors++; $display("FAIL mm_sum: got %0d expected 573", sum_a); end
    checks++; if (avg_a !== 8'd71) begin errors++; $display("FAIL mm_avg: got %0d expected 71", avg_a); end
    checks++; if (odd_a !== 4'd5) begin errors++; $display("FAIL mm_odd: got %0d expected 5", odd_a); end
    checks++; if (min_a !== 8'd3) begin errors++; $display("FAIL mm_min: got %0d expected 3", min_a); end
    checks++; if (max_a !== 8'd201) begin errors++; $display("FAIL mm_max: got %0d expected 201", max_a); end
  endtask

  task automatic test_go_ignored();
    int lat;
    for (int i = 0; i < 8; i++) mem_a[i] = (i == 7) ? 8'd2 : 8'd1;
    go_a = 1'b1;
    tick();
    go_a = 1'b0;
    lat = 0;
    while (!done_a && lat < 60) begin
      go_a = (lat == 2 || lat == 5);
      tick();
      lat++;
    end
    go_a = 1'b0;
    checks++; if (lat !== 9) begin errors++; $display("FAIL ign_latency: got %0d expected 9", lat); end
    checks++; if ({sum_a, avg_a, odd_a, min_a, max_a} !== {11'd9, 8'd1, 4'd7, 8'd1, 8'd2}) begin errors++; $display("FAIL ign_results: sum=%0d avg=%0d odd=%0d min=%0d max=%0d expected 9/1/7/1/2", sum_a, avg_a, odd_a, min_a, max_a); end
    repeat (3) tick();
    checks++; if ({busy_a, done_a, addr_a} !== 5'b01_111) begin errors++; $display("FAIL ign_done_hold: busy=%b done=%b addr=%0d expected 0/1/7", busy_a, done_a, addr_a); end
    checks++; if (sum_a !== 11'd9) begin errors++; $display("FAIL ign_sum_hold: got %0d expected 9", sum_a); end
  endtask

  task automatic test_reset_midrun();
    int lat;
    for (int i = 0; i < 8; i++) mem_a[i] = 8'd100;
    go_a = 1'b1;
    tick();
    go_a = 1'b0;
    repeat (3) tick();
    checks++; if ({busy_a, done_a, sum_a} !== {2'b10, 11'd9}) begin errors++; $display("FAIL rst_pre: busy=%b done=%b sum=%0d expected 1/0/9", busy_a, done_a, sum_a); end
    Rst = 1'b1;
    tick();
    Rst = 1'b0;
    checks++; if ({busy_a, done_a, addr_a} !== 5'd0) begin errors++; $display("FAIL rst_mid_flags: busy=%b done=%b addr=%0d expected 0/0/0", busy_a, done_a, addr_a); end
    checks++; if ({sum_a, avg_a, odd_a, min_a, max_a} !== 39'd0) begin errors++; $display("FAIL rst_mid_results: sum=%0d avg=%0d odd=%0d min=%0d max=%0d expected all 0", sum_a, avg_a, odd_a, min_a, max_a); end
    repeat (12) tick();
    checks++; if ({busy_a, done_a, addr_a, sum_a} !== 16'd0) begin errors++; $display("FAIL rst_idle: busy=%b done=%b addr=%0d sum=%0d expected all 0", busy_a, done_a, addr_a, sum_a); end
    for (int i = 0; i < 8; i++) mem_a[i] = 8'(2 * (i + 1));
    run_a(lat);
    checks++; if (lat !== 9) begin errors++; $display("FAIL rst_fresh_latency: got %0d expected 9", lat); end
    checks++; if ({sum_a, avg_a, odd_a, min_a, max_a} !== {11'd72, 8'd9, 4'd0, 8'd2, 8'd16}) begin errors++; $display("FAIL rst_fresh_results: sum=%0d avg=%0d odd=%0d min=%0d max=%0d expected 72/9/0/2/16", sum_a, avg_a, odd_a, min_a, max_a); end
  endtask

  // go held high across three runs; memory rewritten in each one-cycle DONE window.
  task automatic test_back_to_back();
    int n;
    logic [38:0] exp [3];
    logic [38:0] prev;
    exp[0] = {11'd36,  8'd4,  4'd4, 8'd1, 8'd8};
    exp[1] = {11'd128, 8'd16, 4'd0, 8'd0, 8'd128};
    exp[2] = {11'd40,  8'd5,  4'd8, 8'd5, 8'd5};
    prev   = {11'd72,  8'd9,  4'd0, 8'd2, 8'd16};
    for (int i = 0; i < 8; i++) mem_a[i] = 8'(i + 1);
    go_a = 1'b1;
    tick();
    for (int r = 0; r < 3; r++) begin
      n = 0;
      while (!done_a && n < 60) begin
        checks++; if ({sum_a, avg_a, odd_a, min_a, max_a} !== prev) begin errors++; $display("FAIL b2b_stable_r%0d_c%0d: got %h expected %h", r, n, {sum_a, avg_a, odd_a, min_a, max_a}, prev); end
        tick();
        n++;
      end
      checks++; if (n !== 9) begin errors++; $display("FAIL b2b_latency_r%0d: got %0d expected 9", r, n); end
      checks++; if ({sum_a, avg_a, odd_a, min_a, max_a} !== exp[r]) begin errors++; $display("FAIL b2b_result_r%0d: got %h expected %h", r, {sum_a, avg_a, odd_a, min_a, max_a}, exp[r]); end
      prev = exp[r];
      if (r == 0) for (int i = 0; i < 8; i++) mem_a[i] = (i == 7) ? 8'd128 : 8'd0;
      if (r == 1) for (int i = 0; i < 8; i++) mem_a[i] = 8'd5;
      if (r == 2) go_a = 1'b0;
      tick();
      if (r < 2) begin
        checks++; if ({busy_a, done_a, addr_a} !== 5'b10_000) begin errors++; $display("FAIL b2b_restart_r%0d: busy=%b done=%b addr=%0d expected 1/0/0", r, busy_a, done_a, addr_a); end
      end else begin
        checks++; if ({busy_a, done_a} !== 2'b01) begin errors++; $display("FAIL b2b_final_hold: busy=%b done=%b expected 0/1", busy_a, done_a); end
      end
    end
  endtask

  task automatic test_depth16();
    int lat;
    for (int i = 0; i < 16; i++) mem_b[i] = 4'(i);
    go_b = 1'b1;
    tick();
    go_b = 1'b0;
    checks++; if ({busy_b, addr_b} !== 5'b1_0000) begin errors++; $display("FAIL d16_start: busy=%b addr=%0d expected 1/0", busy_b, addr_b); end
    lat = 0;
    while (!done_b && lat < 80) begin
      tick();
      lat++;
    end
    if (!done_b) lat = -1;
    checks++; if (lat !== 17) begin errors++; $display("FAIL d16_latency: got %0d expected 17", lat); end
    checks++; if (sum_b !== 8'd120) begin errors++; $display("FAIL d16_sum: got %0d expected 120", sum_b); end
    checks++; if (avg_b !== 4'd7) begin errors++; $display("FAIL d16_avg: got %0d expected 7", avg_b); end
    checks++; if (odd_b !== 5'd8) begin errors++; $display("FAIL d16_odd: got %0d expected 8", odd_b); end
    checks++; if ({min_b, max_b} !== {4'd0, 4'd15}) begin errors++; $display("FAIL d16_minmax: min=%0d max=%0d expected 0/15", min_b, max_b); end
    checks++; if (addr_b !== 4'd15) begin errors++; $display("FAIL d16_addr_done: got %0d expected 15", addr_b); end
  endtask

  initial begin
    Rst = 1'b1; go_a = 1'b0; go_b = 1'b0;
    for (int i = 0; i < 8; i++) mem_a[i] = 8'd0;
    for (int i = 0; i < 16; i++) mem_b[i] = 4'd0;
    test_reset();
    test_basic();
    test_extremes();
    test_minmax();
    test_go_ignored();
    test_reset_midrun();
    test_back_to_back();
    test_depth16();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
